mac_dot_seq: RTL and testbench

MAC_DOT_SEQ -- requirements
Module: mac_dot_seq

---
 rtl/mac_seq_pkg.sv | 27 ++
 rtl/mac_dot_seq.sv | 123 ++++++++++++
 tb/tb_mac_dot_seq.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_seq_pkg
//  Description : Shared types and constants for the MAC dot-product sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package mac_seq_pkg;

    localparam int OUT_SEL_MAX = 16;
    localparam int LEN_W       = 4;
    localparam int DATA_W      = 4;
    localparam int SEL_W       = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    // Window selects beyond the top of the accumulator window collapse to the maximum.
    function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] sel);
        return (sel > SEL_W'(OUT_SEL_MAX)) ? SEL_W'(OUT_SEL_MAX) : sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_dot_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mac_dot_seq
//  Description : Job sequencer for a 4-bit MAC. Accepts a job command, streams
//                operand pairs into the MAC, captures the MAC output and
//                presents it on a result handshake. No arithmetic on MAC data.
//  Revision    : 1.0  initial release
// ============================================================================
module mac_dot_seq
    import mac_seq_pkg::*;
(
    input  logic              MAC_ACC_CLK,
    input  logic              MAC_SEQ_RST,

    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [LEN_W-1:0]  CMD_LEN,
    input  logic [SEL_W-1:0]  CMD_OUT_SEL,
    input  logic              CMD_TC,
    input  logic              CMD_SAT,
    input  logic              CMD_RND,

    input  logic              PAIR_VALID,
    output logic              PAIR_READY,
    input  logic [DATA_W-1:0] PAIR_OPER,
    input  logic [DATA_W-1:0] PAIR_COEF,

    output logic              RES_VALID,
    input  logic              RES_READY,
    output logic [DATA_W-1:0] RES_DATA,

    output logic [DATA_W-1:0] MAC_OPER_DATA,
    output logic [DATA_W-1:0] MAC_COEF_DATA,
    output logic              EFPGA_MATHB_CLK_EN,
    output logic              MAC_ACC_CLEAR,
    output logic              MAC_ACC_RND,
    output logic              MAC_ACC_SAT,
    output logic              MAC_TC,
    output logic [SEL_W-1:0]  MAC_OUT_SEL,
    input  logic [DATA_W-1:0] MAC_OUT
);

    state_t             state;
    logic [LEN_W-1:0]   pair_cnt;    // pairs still to accept, minus one
    logic [SEL_W-1:0]   job_sel;
    logic               job_tc;
    logic               job_sat;
    logic               job_rnd;
    logic               first_pair;  // next accepted pair opens the accumulation
    logic [DATA_W-1:0]  res_data;

    logic               pair_fire;

    // Sequencer state, job registers and result capture.
    always_ff @(posedge MAC_ACC_CLK) begin
        if (MAC_SEQ_RST) begin
            state      <= IDLE;
            pair_cnt   <= '0;
            job_sel    <= '0;
            job_tc     <= 1'b0;
            job_sat    <= 1'b0;
            job_rnd    <= 1'b0;
            first_pair <= 1'b0;
            res_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (CMD_VALID) begin
                        // The counter doubles as the registered job length.
                        pair_cnt   <= CMD_LEN;
                        job_sel    <= clamp_sel(CMD_OUT_SEL);
                        job_tc     <= CMD_TC;
                        job_sat    <= CMD_SAT;
                        job_rnd    <= CMD_RND;
                        first_pair <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (PAIR_VALID) begin
                        first_pair <= 1'b0;
                        if (pair_cnt == '0) begin
                            state <= CAPT;
                        end else begin
                            pair_cnt <= pair_cnt - LEN_W'(1);
                        end
                    end
                end
                CAPT: begin
                    // The accumulator took the last pair at the previous edge,
                    // so MAC_OUT is final throughout this cycle.
                    res_data <= MAC_OUT;
                    state    <= RESP;
                end
                RESP: begin
                    if (RES_READY) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake and MAC control decode from the state and job registers.
    always_comb begin
        CMD_READY          = (state == IDLE);
        PAIR_READY         = (state == RUN);
        RES_VALID          = (state == RESP);
        pair_fire          = PAIR_READY & PAIR_VALID;
        EFPGA_MATHB_CLK_EN = pair_fire;
        MAC_ACC_CLEAR      = pair_fire & first_pair & ~job_rnd;
        MAC_ACC_RND        = pair_fire & first_pair &  job_rnd;
        MAC_OPER_DATA      = PAIR_OPER;
        MAC_COEF_DATA      = PAIR_COEF;
        MAC_OUT_SEL        = job_sel;
        MAC_TC             = job_tc;
        MAC_ACC_SAT        = job_sat;
        RES_DATA           = res_data;
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_dot_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_dot_seq
//  Description : Self-checking bench for mac_dot_seq with a behavioural 4-bit
//                MAC attached and a job-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mac_dot_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       CMD_VALID, CMD_READY, CMD_TC, CMD_SAT, CMD_RND;
    logic [3:0] CMD_LEN;
    logic [5:0] CMD_OUT_SEL;
    logic       PAIR_VALID, PAIR_READY;
    logic [3:0] PAIR_OPER, PAIR_COEF;
    logic       RES_VALID, RES_READY;
    logic [3:0] RES_DATA;
    logic [3:0] MAC_OPER_DATA, MAC_COEF_DATA, MAC_OUT;
    logic       EFPGA_MATHB_CLK_EN, MAC_ACC_CLEAR, MAC_ACC_RND, MAC_ACC_SAT, MAC_TC;
    logic [5:0] MAC_OUT_SEL;

    always #5 clk = ~clk;

    mac_dot_seq dut (
        .MAC_ACC_CLK(clk), .MAC_SEQ_RST(rst),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_LEN(CMD_LEN),
        .CMD_OUT_SEL(CMD_OUT_SEL), .CMD_TC(CMD_TC), .CMD_SAT(CMD_SAT), .CMD_RND(CMD_RND),
        .PAIR_VALID(PAIR_VALID), .PAIR_READY(PAIR_READY),
        .PAIR_OPER(PAIR_OPER), .PAIR_COEF(PAIR_COEF),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA),
        .MAC_OPER_DATA(MAC_OPER_DATA), .MAC_COEF_DATA(MAC_COEF_DATA),
        .EFPGA_MATHB_CLK_EN(EFPGA_MATHB_CLK_EN), .MAC_ACC_CLEAR(MAC_ACC_CLEAR),
        .MAC_ACC_RND(MAC_ACC_RND), .MAC_ACC_SAT(MAC_ACC_SAT), .MAC_TC(MAC_TC),
        .MAC_OUT_SEL(MAC_OUT_SEL), .MAC_OUT(MAC_OUT)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- arithmetic helpers (MAC semantics) -------------------
    function automatic longint sval(input logic [3:0] v, input bit tc);
        return (tc && v[3]) ? longint'(v) - 16 : longint'(v);
    endfunction

    function automatic longint prod(input logic [3:0] o, input logic [3:0] c, input bit tc);
        return sval(o, tc) * sval(c, tc);
    endfunction

    function automatic longint seedv(input int sel);
        return (sel == 0) ? 64'sd0 : (longint'(1) <<< (sel - 1));
    endfunction

    function automatic logic [3:0] win(input longint a, input int sel, input bit tc, input bit sat);
        longint v;
        v = a >>> sel;
        if (sat) begin
            if (tc) begin
                if (v > 7)  v = 7;
                if (v < -8) v = -8;
            end else if (v > 15) begin
                v = 15;
            end
        end
        return v[3:0];
    endfunction

    // ---------------- behavioural 4-bit MAC in the parent -----------------
    longint acc = 0;
    always @(posedge clk) begin
        if (EFPGA_MATHB_CLK_EN) begin
            if (MAC_ACC_CLEAR)
                acc <= prod(MAC_OPER_DATA, MAC_COEF_DATA, MAC_TC);
            else if (MAC_ACC_RND)
                acc <= seedv(int'(MAC_OUT_SEL)) + prod(MAC_OPER_DATA, MAC_COEF_DATA, MAC_TC);
            else
                acc <= acc + prod(MAC_OPER_DATA, MAC_COEF_DATA, MAC_TC);
        end
    end
    assign MAC_OUT = win(acc, int'(MAC_OUT_SEL), MAC_TC, MAC_ACC_SAT);

    // ---------------- job-level reference model ---------------------------
    bit         m_live = 0;
    bit         m_busy, m_first, m_tc, m_sat, m_rnd;
    int         m_left, m_after, m_sel;
    longint     m_sum;
    logic [3:0] m_res;

    always @(posedge clk) begin
        if (rst) begin
            m_live <= 1; m_busy <= 0; m_first <= 0;
            m_tc <= 0; m_sat <= 0; m_rnd <= 0;
            m_left <= 0; m_after <= 0; m_sel <= 0; m_sum <= 0; m_res <= 0;
        end else if (m_live) begin
            if (!m_busy) begin
                if (CMD_VALID) begin
                    m_busy  <= 1;
                    m_left  <= int'(CMD_LEN) + 1;
                    m_after <= 0;
                    m_sel   <= (CMD_OUT_SEL > 6'd16) ? 16 : int'(CMD_OUT_SEL);
                    m_tc    <= CMD_TC;
                    m_sat   <= CMD_SAT;
                    m_rnd   <= CMD_RND;
                    m_first <= 1;
                end
            end else if (m_left > 0) begin
                if (PAIR_VALID) begin
                    if (m_first)
                        m_sum <= (m_rnd ? seedv(m_sel) : 64'sd0) + prod(PAIR_OPER, PAIR_COEF, m_tc);
                    else
                        m_sum <= m_sum + prod(PAIR_OPER, PAIR_COEF, m_tc);
                    m_first <= 0;
                    m_left  <= m_left - 1;
                end
            end else if (m_after == 0) begin
                m_after <= 1;
                m_res   <= win(m_sum, m_sel, m_tc, m_sat);
            end else if (RES_READY) begin
                m_busy <= 0;
            end
        end
    end

    // Per-cycle comparison of every sequencer output against the model.
    always @(negedge clk) begin
        if (m_live) begin
            bit pr, fire, rv;
            pr   = m_busy && (m_left > 0);
            fire = pr && PAIR_VALID;
            rv   = m_busy && (m_left == 0) && (m_after >= 1);
            chk("cmd_ready",  int'(CMD_READY),          int'(!m_busy));
            chk("pair_ready", int'(PAIR_READY),         int'(pr));
            chk("clk_en",     int'(EFPGA_MATHB_CLK_EN), int'(fire));
            chk("acc_clear",  int'(MAC_ACC_CLEAR),      int'(fire && m_first && !m_rnd));
            chk("acc_rnd",    int'(MAC_ACC_RND),        int'(fire && m_first && m_rnd));
            chk("res_valid",  int'(RES_VALID),          int'(rv));
            chk("out_sel",    int'(MAC_OUT_SEL),        m_sel);
            chk("mac_tc",     int'(MAC_TC),             int'(m_tc));
            chk("mac_sat",    int'(MAC_ACC_SAT),        int'(m_sat));
            chk("oper_pass",  int'(MAC_OPER_DATA),      int'(PAIR_OPER));
            chk("coef_pass",  int'(MAC_COEF_DATA),      int'(PAIR_COEF));
            if (rv) chk("res_data_model", int'(RES_DATA), int'(m_res));
        end
    end

    // ---------------- directed stimulus -----------------------------------
    logic [3:0] ops [16];
    logic [3:0] cfs [16];

    task automatic send_cmd(input int len, input int sel, input bit tc, input bit sat, input bit rnd);
        bit hs;
        CMD_VALID = 1; CMD_LEN = 4'(len); CMD_OUT_SEL = 6'(sel);
        CMD_TC = tc; CMD_SAT = sat; CMD_RND = rnd;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); hs = CMD_READY;
            @(posedge clk); #1;
            if (hs) break;
            if (k == 19) chk("cmd_timeout", 1, 0);
        end
        CMD_VALID = 0;
    endtask

    task automatic send_pairs(input int n, input int gap, input bit rnd);
        bit hs, clr, rd;
        for (int i = 0; i < n; i++) begin
            repeat (gap) begin @(posedge clk); #1; end
            PAIR_VALID = 1; PAIR_OPER = ops[i]; PAIR_COEF = cfs[i];
            for (int k = 0; k < 20; k++) begin
                @(negedge clk); hs = PAIR_READY; clr = MAC_ACC_CLEAR; rd = MAC_ACC_RND;
                @(posedge clk); #1;
                if (hs) break;
                if (k == 19) chk("pair_timeout", 1, 0);
            end
            chk("clear_on_pair", int'(clr), int'(i == 0 && !rnd));
            chk("rnd_on_pair",   int'(rd),  int'(i == 0 && rnd));
            PAIR_VALID = 0; PAIR_OPER = 0; PAIR_COEF = 0;
        end
    endtask

    task automatic get_res(input int hold, input logic [3:0] lit);
        logic [3:0] first;
        @(negedge clk); chk("valid_low_in_capt", int'(RES_VALID), 0);
        @(negedge clk); chk("valid_two_edges",   int'(RES_VALID), 1);
        first = RES_DATA;
        repeat (hold) begin
            @(negedge clk);
            chk("res_stable", int'(RES_DATA), int'(first));
            chk("cmd_blocked", int'(CMD_READY), 0);
        end
        @(posedge clk); #1; RES_READY = 1;
        @(negedge clk); chk("res_literal", int'(RES_DATA), int'(lit));
        @(posedge clk); #1; RES_READY = 0;
        @(negedge clk); chk("idle_after_resp", int'(CMD_READY), 1);
        @(posedge clk); #1;
    endtask

    task automatic run_job(input int len, input int sel, input bit tc, input bit sat,
                           input bit rnd, input int gap, input int hold, input logic [3:0] lit);
        send_cmd(len, sel, tc, sat, rnd);
        send_pairs(len + 1, gap, rnd);
        get_res(hold, lit);
    endtask

    initial begin
        rst = 1; CMD_VALID = 0; CMD_LEN = 0; CMD_OUT_SEL = 0; CMD_TC = 0; CMD_SAT = 0; CMD_RND = 0;
        PAIR_VALID = 0; PAIR_OPER = 0; PAIR_COEF = 0; RES_READY = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_cmd_ready", int'(CMD_READY), 1);
        chk("rst_res_valid", int'(RES_VALID), 0);
        chk("rst_res_data",  int'(RES_DATA), 0);
        chk("rst_out_sel",   int'(MAC_OUT_SEL), 0);
        chk("rst_clk_en",    int'(EFPGA_MATHB_CLK_EN), 0);
        @(posedge clk); #1;

        // unsigned single pair 3x5 = 15
        ops[0] = 3; cfs[0] = 5;
        run_job(0, 0, 0, 0, 0, 0, 0, 4'hF);

        // unsigned 3x5 + 1x1 = 16: wraps, then saturates
        ops[1] = 1; cfs[1] = 1;
        run_job(1, 0, 0, 0, 0, 0, 0, 4'h0);
        run_job(1, 0, 0, 1, 0, 0, 0, 4'hF);

        // signed -8 x 7 = -56, saturated
        ops[0] = 4'h8; cfs[0] = 4'h7;
        run_job(0, 0, 1, 1, 0, 0, 0, 4'h8);

        // rounding seed 2 + 3x1 = 5, window >> 2
        ops[0] = 3; cfs[0] = 1;
        run_job(0, 2, 0, 0, 1, 0, 0, 4'h1);

        // 2x3 + 4x1 + 1x5 = 15 without and with stalls / backpressure
        ops[0] = 2; cfs[0] = 3; ops[1] = 4; cfs[1] = 1; ops[2] = 1; cfs[2] = 5;
        run_job(2, 0, 0, 0, 0, 0, 0, 4'hF);
        run_job(2, 0, 0, 0, 0, 3, 5, 4'hF);

        // window select above 16 clamps to 16: 225 >> 16 = 0
        ops[0] = 4'hF; cfs[0] = 4'hF;
        run_job(0, 40, 0, 0, 0, 0, 0, 4'h0);

        // maximum length: 16 x (1x1) = 16, saturated
        for (int i = 0; i < 16; i++) begin ops[i] = 1; cfs[i] = 1; end
        run_job(15, 0, 0, 1, 0, 0, 0, 4'hF);

        // reset after the second pair of a four-pair job
        ops[0] = 7; cfs[0] = 7; ops[1] = 7; cfs[1] = 7;
        send_cmd(3, 0, 0, 0, 0);
        send_pairs(2, 0, 0);
        rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("abort_idle",     int'(CMD_READY), 1);
        chk("abort_no_valid", int'(RES_VALID), 0);
        @(posedge clk); #1;
        ops[0] = 3; cfs[0] = 5;
        run_job(0, 0, 0, 0, 0, 0, 0, 4'hF);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
